// File: rtl/alu_op_sequencer.sv
// alu_op_sequencer: multi-cycle instruction sequencer in front of a shared
// combinational ALU and a register file.
//   Instruction in : INSTR_VALID/INSTR_READY handshake, INSTR (32b)
//   RF read        : RF_RADDR1/2 (rs/rt of latched instruction), RF_RDATA1/2
//   ALU drive      : ALU_OPCODE, ALU_RS_VAL, ALU_RT_VAL, ALU_SHAMT, ALU_FUNC,
//                    ALU_RAW_VAL; results ALU_RESULT, ALU_SIG_B
//   Writeback      : RF_WE (strobe), RF_WADDR, RF_WDATA
//   Branch         : BR_VALID (strobe), BR_TAKEN
//   Status         : ILLEGAL (strobe), DONE (strobe), BUSY
// Sequence per instruction: IDLE -> READ -> EXEC (EXEC_CYCLES) -> WB -> IDLE.
module alu_op_sequencer #(
    parameter int unsigned EXEC_CYCLES = 1
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        INSTR_VALID,
    output logic        INSTR_READY,
    input  logic [31:0] INSTR,
    output logic [4:0]  RF_RADDR1,
    output logic [4:0]  RF_RADDR2,
    input  logic [31:0] RF_RDATA1,
    input  logic [31:0] RF_RDATA2,
    output logic [5:0]  ALU_OPCODE,
    output logic [31:0] ALU_RS_VAL,
    output logic [31:0] ALU_RT_VAL,
    output logic [4:0]  ALU_SHAMT,
    output logic [5:0]  ALU_FUNC,
    output logic [15:0] ALU_RAW_VAL,
    input  logic [31:0] ALU_RESULT,
    input  logic        ALU_SIG_B,
    output logic        RF_WE,
    output logic [4:0]  RF_WADDR,
    output logic [31:0] RF_WDATA,
    output logic        BR_VALID,
    output logic        BR_TAKEN,
    output logic        ILLEGAL,
    output logic        DONE,
    output logic        BUSY
);

    localparam int unsigned CNT_W  = 4;
    localparam int unsigned OP_W   = 6;
    localparam int unsigned DATA_W = 32;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_READ = 2'd1,
        S_EXEC = 2'd2,
        S_WB   = 2'd3
    } state_t;

    state_t            state;
    state_t            state_nxt;
    logic [DATA_W-1:0] instr;
    logic [CNT_W-1:0]  cnt;
    logic              cnt_zero;
    logic [OP_W-1:0]   opcode;
    logic              is_rtype;
    logic              is_branch;
    logic              is_illegal;
    logic              is_itype;

    assign cnt_zero = (cnt == '0);
    assign opcode   = instr[31:26];

    // Opcode classes of the latched instruction
    assign is_rtype   = (opcode == 6'b000000);
    assign is_branch  = (opcode == 6'b000100) || (opcode == 6'b000101);
    assign is_illegal = (opcode == 6'b000010) || (opcode == 6'b000011) ||
                        (opcode == 6'b100011) || (opcode == 6'b101011);
    assign is_itype   = !is_rtype && !is_branch && !is_illegal;

    // Source register addresses come straight from the latched instruction
    assign RF_RADDR1 = instr[25:21];
    assign RF_RADDR2 = instr[20:16];

    // State register
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (INSTR_VALID) state_nxt = S_READ;
            S_READ:  state_nxt = S_EXEC;
            S_EXEC:  if (cnt_zero) state_nxt = S_WB;
            S_WB:    state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // Output decode; strobes are only ever high in WB
    always_comb begin
        INSTR_READY = 1'b0;
        BUSY        = 1'b1;
        DONE        = 1'b0;
        RF_WE       = 1'b0;
        BR_VALID    = 1'b0;
        ILLEGAL     = 1'b0;
        case (state)
            S_IDLE: begin
                INSTR_READY = 1'b1;
                BUSY        = 1'b0;
            end
            S_WB: begin
                DONE     = 1'b1;
                BR_VALID = is_branch;
                ILLEGAL  = is_illegal;
                RF_WE    = (is_rtype && (instr[15:11] != 5'd0)) ||
                           (is_itype && (instr[20:16] != 5'd0));
            end
            default: ;
        endcase
    end

    // Instruction latch, ALU operand registers, settle counter, result capture
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            instr       <= '0;
            cnt         <= '0;
            ALU_OPCODE  <= '0;
            ALU_RS_VAL  <= '0;
            ALU_RT_VAL  <= '0;
            ALU_SHAMT   <= '0;
            ALU_FUNC    <= '0;
            ALU_RAW_VAL <= '0;
            RF_WADDR    <= '0;
            RF_WDATA    <= '0;
            BR_TAKEN    <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (INSTR_VALID) instr <= INSTR;
                end
                S_READ: begin
                    ALU_RS_VAL  <= RF_RDATA1;
                    ALU_RT_VAL  <= RF_RDATA2;
                    ALU_OPCODE  <= instr[31:26];
                    ALU_SHAMT   <= instr[10:6];
                    ALU_FUNC    <= instr[5:0];
                    ALU_RAW_VAL <= instr[15:0];
                    cnt         <= CNT_W'(EXEC_CYCLES - 1);
                end
                S_EXEC: begin
                    if (cnt_zero) begin
                        RF_WDATA <= ALU_RESULT;
                        BR_TAKEN <= ALU_SIG_B;
                        // Destination only meaningful for register-writing classes
                        if (is_rtype) RF_WADDR <= instr[15:11];
                        else if (is_itype) RF_WADDR <= instr[20:16];
                    end else begin
                        cnt <= cnt - CNT_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Bench for alu_op_sequencer: instance a (EXEC_CYCLES=1) with a register-file
// model and random instruction stream; instance b (EXEC_CYCLES=3) for latency
// and back-to-back throughput.
module tb_alu_op_sequencer;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // ALU stand-in: an arbitrary mix of every operand so any wrong input shows
    function automatic logic [31:0] alu_stub(input logic [5:0] op, input logic [31:0] rs,
                                             input logic [31:0] rt, input logic [4:0] sh,
                                             input logic [5:0] fn, input logic [15:0] raw);
        return (rs + 32'(sh)) ^ {rt[15:0], rt[31:16]} ^ {op, fn, 4'b0000, raw};
    endfunction

    // Fixed read data for instance b, derived from the address
    function automatic logic [31:0] rdb(input logic [4:0] a);
        return {a, a, a, a, a, a, 2'b10};
    endfunction

    // ---------------- instance a ----------------
    logic        a_valid = 1'b0, a_ready;
    logic [31:0] a_instr = '0;
    logic [4:0]  a_raddr1, a_raddr2;
    logic [31:0] a_rdata1, a_rdata2;
    logic [5:0]  a_op, a_fn;
    logic [31:0] a_rs, a_rt, a_res, a_wd;
    logic [4:0]  a_sh, a_wa;
    logic [15:0] a_raw;
    logic        a_sigb = 1'b0;
    logic        a_we, a_bv, a_bt, a_ill, a_done, a_busy;

    logic [31:0] rf     [32];
    logic [31:0] ref_rf [32];

    assign a_rdata1 = (a_raddr1 == 5'd0) ? 32'd0 : rf[a_raddr1];
    assign a_rdata2 = (a_raddr2 == 5'd0) ? 32'd0 : rf[a_raddr2];
    assign a_res    = alu_stub(a_op, a_rs, a_rt, a_sh, a_fn, a_raw);

    alu_op_sequencer #(.EXEC_CYCLES(1)) dut_a (
        .CLK(clk), .RST(rst),
        .INSTR_VALID(a_valid), .INSTR_READY(a_ready), .INSTR(a_instr),
        .RF_RADDR1(a_raddr1), .RF_RADDR2(a_raddr2),
        .RF_RDATA1(a_rdata1), .RF_RDATA2(a_rdata2),
        .ALU_OPCODE(a_op), .ALU_RS_VAL(a_rs), .ALU_RT_VAL(a_rt),
        .ALU_SHAMT(a_sh), .ALU_FUNC(a_fn), .ALU_RAW_VAL(a_raw),
        .ALU_RESULT(a_res), .ALU_SIG_B(a_sigb),
        .RF_WE(a_we), .RF_WADDR(a_wa), .RF_WDATA(a_wd),
        .BR_VALID(a_bv), .BR_TAKEN(a_bt), .ILLEGAL(a_ill),
        .DONE(a_done), .BUSY(a_busy)
    );

    // ---------------- instance b ----------------
    logic        b_valid = 1'b0, b_ready;
    logic [31:0] b_instr = '0;
    logic [4:0]  b_raddr1, b_raddr2;
    logic [31:0] b_rdata1, b_rdata2;
    logic [5:0]  b_op, b_fn;
    logic [31:0] b_rs, b_rt, b_res, b_wd;
    logic [4:0]  b_sh, b_wa;
    logic [15:0] b_raw;
    logic        b_sigb = 1'b0;
    logic        b_we, b_bv, b_bt, b_ill, b_done, b_busy;

    assign b_rdata1 = rdb(b_raddr1);
    assign b_rdata2 = rdb(b_raddr2);
    assign b_res    = alu_stub(b_op, b_rs, b_rt, b_sh, b_fn, b_raw);

    alu_op_sequencer #(.EXEC_CYCLES(3)) dut_b (
        .CLK(clk), .RST(rst),
        .INSTR_VALID(b_valid), .INSTR_READY(b_ready), .INSTR(b_instr),
        .RF_RADDR1(b_raddr1), .RF_RADDR2(b_raddr2),
        .RF_RDATA1(b_rdata1), .RF_RDATA2(b_rdata2),
        .ALU_OPCODE(b_op), .ALU_RS_VAL(b_rs), .ALU_RT_VAL(b_rt),
        .ALU_SHAMT(b_sh), .ALU_FUNC(b_fn), .ALU_RAW_VAL(b_raw),
        .ALU_RESULT(b_res), .ALU_SIG_B(b_sigb),
        .RF_WE(b_we), .RF_WADDR(b_wa), .RF_WDATA(b_wd),
        .BR_VALID(b_bv), .BR_TAKEN(b_bt), .ILLEGAL(b_ill),
        .DONE(b_done), .BUSY(b_busy)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    // Reference writeback rules by opcode class
    task automatic model(input logic [31:0] ins, output logic we, output logic [4:0] wa,
                         output logic wa_ok, output logic bv, output logic ill);
        logic [5:0] op;
        op = ins[31:26];
        we = 1'b0; wa = 5'd0; wa_ok = 1'b0; bv = 1'b0; ill = 1'b0;
        case (op)
            6'd0:                     begin wa = ins[15:11]; wa_ok = 1'b1; we = (wa != 5'd0); end
            6'd4, 6'd5:               bv = 1'b1;
            6'd2, 6'd3, 6'd35, 6'd43: ill = 1'b1;
            default:                  begin wa = ins[20:16]; wa_ok = 1'b1; we = (wa != 5'd0); end
        endcase
    endtask

    task automatic chk_reset_a(input string tag);
        chk({tag, "_ready"}, 32'(a_ready), 1);
        chk({tag, "_busy"},  32'(a_busy), 0);
        chk({tag, "_strb"},  32'({a_we, a_bv, a_ill, a_done}), 0);
        chk({tag, "_alu"},   a_rs | a_rt | 32'({a_op, a_sh, a_fn, a_raw}), 0);
        chk({tag, "_rf"},    a_wd | 32'({a_wa, a_bt, a_raddr1, a_raddr2}), 0);
    endtask

    // One instruction through instance a, checked cycle by cycle (handshake = cycle 0)
    task automatic run_a(input logic [31:0] ins, input logic sb);
        logic [31:0] rsv, rtv, res, junk;
        logic        we, wa_ok, bv, ill;
        logic [4:0]  wa;
        @(negedge clk);
        chk("a_ready_pre", 32'(a_ready), 1);
        a_instr = ins; a_valid = 1'b1; a_sigb = sb;
        @(posedge clk); #1;
        junk = $urandom;
        a_valid = 1'b0; a_instr = junk;
        // cycle 1: READ
        chk("a_raddr1", 32'(a_raddr1), 32'(ins[25:21]));
        chk("a_raddr2", 32'(a_raddr2), 32'(ins[20:16]));
        chk("a_read_status", 32'({a_ready, a_busy, a_done, a_we}), 32'(4'b0100));
        rsv = (ins[25:21] == 5'd0) ? 32'd0 : ref_rf[ins[25:21]];
        rtv = (ins[20:16] == 5'd0) ? 32'd0 : ref_rf[ins[20:16]];
        @(posedge clk); #1;
        // cycle 2: EXEC
        chk("a_alu_rs", a_rs, rsv);
        chk("a_alu_rt", a_rt, rtv);
        chk("a_alu_fields", 32'({a_op, a_sh, a_fn, a_raw}),
            32'({ins[31:26], ins[10:6], ins[5:0], ins[15:0]}));
        chk("a_exec_strb", 32'({a_we, a_bv, a_ill, a_done}), 0);
        res = alu_stub(ins[31:26], rsv, rtv, ins[10:6], ins[5:0], ins[15:0]);
        model(ins, we, wa, wa_ok, bv, ill);
        @(posedge clk); #1;
        // cycle 3: WB
        chk("a_wb_done", 32'(a_done), 1);
        chk("a_wb_we", 32'(a_we), 32'(we));
        chk("a_wb_brv", 32'(a_bv), 32'(bv));
        chk("a_wb_ill", 32'(a_ill), 32'(ill));
        chk("a_wb_wdata", a_wd, res);
        chk("a_wb_brtaken", 32'(a_bt), 32'(sb));
        if (wa_ok) chk("a_wb_waddr", 32'(a_wa), 32'(wa));
        if (a_we) rf[a_wa] = a_wd;
        if (we) ref_rf[wa] = res;
        @(posedge clk); #1;
        // cycle 4: back in IDLE, strobes drop, data holds
        chk("a_idle_status", 32'({a_ready, a_busy, a_done, a_we, a_bv, a_ill}), 32'(6'b100000));
        chk("a_idle_wdata", a_wd, res);
    endtask

    initial begin
        logic [31:0] r, i1, i2, res1, res2;
        logic [5:0]  ops [10];
        ops = '{6'd0, 6'd0, 6'd4, 6'd5, 6'd2, 6'd35, 6'd43, 6'd8, 6'd13, 6'd15};

        rf[0] = '0; ref_rf[0] = '0;
        for (int i = 1; i < 32; i++) begin
            r = $urandom;
            rf[i] = r; ref_rf[i] = r;
        end
        rf[1] = 32'd15; ref_rf[1] = 32'd15;
        rf[2] = 32'd12; ref_rf[2] = 32'd12;

        // Reset values
        #2;
        chk_reset_a("rst_a");
        chk("rst_b_ready", 32'(b_ready), 1);
        chk("rst_b_outs", b_wd | b_rs | 32'({b_busy, b_done, b_we, b_bv, b_ill, b_bt}), 0);
        @(negedge clk); @(negedge clk);
        rst = 1'b0;

        // Directed: SRA, branch taken/not taken, rd=0, lw
        run_a(32'h00221843, 1'b0);
        run_a(32'h10220004, 1'b1);
        run_a(32'h10220004, 1'b0);
        run_a(32'h00220043, 1'b1);
        run_a(32'h8C220000, 1'b1);

        // Reset during EXEC of an R-type: no write, immediate IDLE
        @(negedge clk);
        a_instr = 32'h00221843; a_valid = 1'b1;
        @(posedge clk); #1 a_valid = 1'b0;
        @(posedge clk); #1;
        chk("mid_in_exec", 32'(a_busy), 1);
        rst = 1'b1;
        #1;
        chk_reset_a("mid_rst");
        @(negedge clk);
        rst = 1'b0;
        for (int c = 0; c < 4; c++) begin
            @(posedge clk); #1;
            chk("mid_no_we", 32'({a_we, a_done, a_ready}), 32'(3'b001));
        end

        // Random instruction stream
        for (int n = 0; n < 40; n++) begin
            r = $urandom;
            i1 = {ops[$urandom_range(0, 9)], r[25:0]};
            run_a(i1, 1'($urandom_range(0, 1)));
        end

        // Instance b: EXEC_CYCLES=3, two instructions with INSTR_VALID held high
        i1 = 32'h00A61822;
        i2 = 32'h20870010;
        res1 = alu_stub(i1[31:26], rdb(i1[25:21]), rdb(i1[20:16]), i1[10:6], i1[5:0], i1[15:0]);
        res2 = alu_stub(i2[31:26], rdb(i2[25:21]), rdb(i2[20:16]), i2[10:6], i2[5:0], i2[15:0]);
        @(negedge clk);
        b_instr = i1; b_valid = 1'b1;
        @(posedge clk); #1;
        b_instr = i2;
        chk("b_c1_ready", 32'(b_ready), 0);
        for (int c = 2; c <= 4; c++) begin
            @(posedge clk); #1;
            chk("b_exec_rs", b_rs, rdb(i1[25:21]));
            chk("b_exec_rt", b_rt, rdb(i1[20:16]));
            chk("b_exec_fields", 32'({b_op, b_sh, b_fn, b_raw}),
                32'({i1[31:26], i1[10:6], i1[5:0], i1[15:0]}));
            chk("b_exec_status", 32'({b_busy, b_done, b_ready}), 32'(3'b100));
        end
        @(posedge clk); #1;
        chk("b_c5_wb", 32'({b_done, b_we, b_wa}), 32'({2'b11, 5'd3}));
        chk("b_c5_wdata", b_wd, res1);
        @(posedge clk); #1;
        chk("b_c6_idle", 32'({b_ready, b_busy, b_done}), 32'(3'b100));
        @(posedge clk); #1;
        chk("b_c7_second", 32'({b_busy, b_raddr1, b_raddr2}), 32'({1'b1, 5'd4, 5'd7}));
        b_valid = 1'b0;
        for (int c = 8; c <= 11; c++) begin
            @(posedge clk); #1;
            chk("b_second_done", 32'(b_done), 32'(c == 11));
        end
        chk("b_c11_wb", 32'({b_we, b_wa}), 32'({1'b1, 5'd7}));
        chk("b_c11_wdata", b_wd, res2);
        @(posedge clk); #1;
        chk("b_c12_idle", 32'({b_ready, b_busy}), 32'(2'b10));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
